ram_multi_read_port: RTL and testbench
======================================

Name: ram_multi_read_port

Overview:
Parametrised synchronous RAM with one write port and NUM_READ independent registered read ports. It is the next generation of the team's dual-read-port RAM and is used as the register file and scratch memory in the datapath. Additions over the previous generation: arbitrary read-port count, out-of-range address checking, and a hardware clear sequencer that sweeps the array to CLEAR_VALUE after reset or on request, with a ready handshake.

Parameters:
DATA_WIDTH, 16, width of each word.
ADDR_WIDTH, 8, width of each address.
MEM_SIZE, 256, number of words; valid addresses are 0..MEM_SIZE-1; must be ≤ 2**ADDR_WIDTH.
NUM_READ, 2, number of read ports; must be ≥ 1.
CLEAR_VALUE, 0, word written to every location by the clear sweep.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
iClear  input  1  single-cycle request to start a clear sweep; honoured only in READY.
iWriteEnable  input  1  write request.
iWriteAddress  input  ADDR_WIDTH  write address.
iDataIn  input  DATA_WIDTH  write data.
iReadAddress  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
oDataOut  output  NUM_READ*DATA_WIDTH  packed registered read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
oReady  output  1  high in READY; writes are accepted only while high.
oAddrError  output  1  one-cycle pulse when a write or read address is ≥ MEM_SIZE.

Behaviour:
- Reset asserted (Reset=0, asynchronous): state←CLEAR, sweep counter←0, oDataOut←0, oReady←0, oAddrError←0. Array contents are undefined until the sweep completes.
- FSM state CLEAR:
  - Each cycle writes CLEAR_VALUE to Ram[counter], then increments the counter.
  - After the write to address MEM_SIZE-1, the state goes to READY. This takes exactly MEM_SIZE cycles after reset deasserts.
  - External writes and iClear are ignored. oDataOut is held at 0. oAddrError stays 0.
- FSM state READY:
  - oReady=1.
  - iClear=1: counter←0 and state←CLEAR on the next edge. A write presented in the same cycle is dropped.
- Write accepted when iWriteEnable=1, oReady=1, iClear=0 and iWriteAddress < MEM_SIZE. The array updates on that edge.
- Read, each port independently:
  - Latency is 1 cycle. oDataOut[k] at edge n+1 reflects the address presented at edge n.
  - An address ≥ MEM_SIZE returns 0.
- Write/read collision: read address equal to an accepted write address in the same cycle; behaviour is set by RAM_BYPASS_EN (see Optional Feature).
- Multiple read ports may present the same address; all return identical data.
- oAddrError: registered and high for exactly one cycle after any cycle in READY that has an out-of-range address, either an enabled write or any read port.
- Reset mid-sweep restarts the sweep from address 0. iClear during CLEAR does not extend the sweep.

Optional Feature:
Macro RAM_BYPASS_EN.
- Defined: write-first forwarding. A read port whose address equals an accepted write address in the same cycle returns iDataIn.
- Undefined: read-first. The port returns the pre-write contents, and the new data is visible from the next read.
- Non-accepted writes never forward in either mode (during CLEAR, out of range, or iClear=1).

Test Plan:
- Reset release, MEM_SIZE=16, CLEAR_VALUE=16'hA5A5 -> oReady=0 for 16 cycles then 1; all 16 addresses read back 16'hA5A5 on every port.
- Write 16'h1234 to addr 3, next cycle read addr 3 on port 0 and addr 4 on port 1 -> port 0 = 16'h1234, port 1 = CLEAR_VALUE, both 1 cycle later.
- Write 16'hBEEF to addr 5 while port 1 reads addr 5 in the same cycle -> 16'hBEEF with RAM_BYPASS_EN, old value 16'hA5A5 without it.
- Write to addr 20 with MEM_SIZE=16 -> oAddrError pulses 1 cycle; no array location changes; a read of addr 20 returns 0.
- iClear in READY together with a write of 16'h0F0F to addr 2 -> write dropped, oReady=0 for 16 cycles, addr 2 reads CLEAR_VALUE afterwards.
- Reset asserted at sweep count 7 and released -> sweep restarts from 0; oReady rises 16 cycles after release; writes during the sweep have no effect.

Source files
------------

// File: rtl/ram_multi_read_port.sv
// Synchronous RAM: one write port, NUM_READ registered read ports, address range checks and a clear sweeper.
// Define RAM_BYPASS_EN for write-first forwarding; the default build is read-first.

module ram_multi_read_port_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  wr_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  oob,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic hit;

    assign oob = ({1'b0, raddr} >= LIM);

`ifdef RAM_BYPASS_EN
    assign hit = wr_fire && (wr_addr == raddr);
`else
    logic unused_wr;
    assign unused_wr = ^{wr_fire, wr_addr};
    assign hit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            dout <= '0;
        else if (!rd_en || oob)
            dout <= '0;
        else if (hit)
            dout <= wr_data;
        else
            dout <= word;
    end
endmodule

module ram_multi_read_port #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    MEM_SIZE    = 256,
    parameter int                    NUM_READ    = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iClear,
    input  logic                           iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH-1:0]          iDataIn,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
    output logic                           oReady,
    output logic                           oAddrError
);
    localparam int                  IW   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LIM  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [IW-1:0]       LAST = IW'(MEM_SIZE-1);

    typedef enum logic {CLEAR, READY} state_t;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    state_t                              state;
    logic [IW-1:0]                       cnt;
    logic [DATA_WIDTH-1:0]               ram [0:MEM_SIZE-1];
    wr_req_t                             wr;
    logic                                in_ready;
    logic                                wr_oob;
    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] raddr;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] rword;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] dout;
    logic [NUM_READ-1:0]                 rd_oob;

    assign in_ready = (state == READY);
    assign wr_oob   = ({1'b0, iWriteAddress} >= LIM);
    assign raddr    = iReadAddress;
    assign oDataOut = dout;

    // iClear wins over a same-cycle write; out-of-range writes never land.
    assign wr.en   = in_ready && iWriteEnable && !iClear && !wr_oob;
    assign wr.addr = iWriteAddress;
    assign wr.data = iDataIn;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            oReady     <= 1'b0;
            oAddrError <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    oAddrError <= 1'b0;
                    if (cnt == LAST) begin
                        state  <= READY;
                        oReady <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    oAddrError <= (iWriteEnable && wr_oob) || (|rd_oob);
                    if (iClear) begin
                        state  <= CLEAR;
                        oReady <= 1'b0;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    oReady <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge Clock) begin
        if (state == CLEAR)
            ram[cnt] <= CLEAR_VALUE;
        else if (wr.en)
            ram[wr.addr[IW-1:0]] <= wr.data;
    end

    genvar k;
    generate
        for (k = 0; k < NUM_READ; k++) begin : g_rd
            // Aliased index for out-of-range addresses is masked by the lane.
            assign rword[k] = ram[raddr[k][IW-1:0]];

            ram_multi_read_port_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .ADDR_WIDTH(ADDR_WIDTH),
                .MEM_SIZE  (MEM_SIZE)
            ) u_lane (
                .Clock  (Clock),
                .Reset  (Reset),
                .rd_en  (in_ready),
                .raddr  (raddr[k]),
                .word   (rword[k]),
                .wr_fire(wr.en),
                .wr_addr(wr.addr),
                .wr_data(wr.data),
                .oob    (rd_oob[k]),
                .dout   (dout[k])
            );
        end
    endgenerate
endmodule

// File: tb/tb_ram_multi_read_port.sv
// Self-checking bench for ram_multi_read_port: directed table, corner sequences, random vs. reference model.
module tb_ram_multi_read_port;
    localparam int          DW = 16;
    localparam int          AW = 8;
    localparam int          MS = 16;
    localparam int          NR = 2;
    localparam logic [15:0] CV = 16'hA5A5;
`ifdef RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic           iClear = 1'b0;
    logic           iWriteEnable = 1'b0;
    logic [AW-1:0]  iWriteAddress = '0;
    logic [DW-1:0]  iDataIn = '0;
    logic [NR*AW-1:0] iReadAddress = '0;
    logic [NR*DW-1:0] oDataOut;
    logic           oReady;
    logic           oAddrError;

    ram_multi_read_port #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_READ(NR), .CLEAR_VALUE(CV)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iClear(iClear), .iWriteEnable(iWriteEnable),
        .iWriteAddress(iWriteAddress), .iDataIn(iDataIn), .iReadAddress(iReadAddress),
        .oDataOut(oDataOut), .oReady(oReady), .oAddrError(oAddrError)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    // Reference: memory as an array, sweep as "busy for MS edges, then all CV".
    logic [15:0] m_mem [MS];
    bit          m_ready;
    int          m_left;
    logic [15:0] m_d [NR];
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = MS;
        m_err   = 1'b0;
        for (int k = 0; k < NR; k++) m_d[k] = '0;
    endtask

    task automatic model_edge();
        logic [7:0] ra [NR];
        bit         acc;
        for (int k = 0; k < NR; k++) ra[k] = iReadAddress[k*AW +: AW];
        if (!m_ready) begin
            for (int k = 0; k < NR; k++) m_d[k] = '0;
            m_err = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < MS; i++) m_mem[i] = CV;
            end
        end else begin
            acc   = iWriteEnable && !iClear && (int'(iWriteAddress) < MS);
            m_err = iWriteEnable && (int'(iWriteAddress) >= MS);
            for (int k = 0; k < NR; k++) begin
                if (int'(ra[k]) >= MS) begin
                    m_d[k] = '0;
                    m_err  = 1'b1;
                end else if (BYP && acc && iWriteAddress == ra[k])
                    m_d[k] = iDataIn;
                else
                    m_d[k] = m_mem[ra[k][3:0]];
            end
            if (acc) m_mem[iWriteAddress[3:0]] = iDataIn;
            if (iClear) begin
                m_ready = 1'b0;
                m_left  = MS;
            end
        end
    endtask

    task automatic step(input bit clr, input bit we, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [7:0] r0, input logic [7:0] r1);
        iClear        = clr;
        iWriteEnable  = we;
        iWriteAddress = wa;
        iDataIn       = wd;
        iReadAddress  = {r1, r0};
        @(posedge Clock);
        model_edge();
        #1;
        chk("model_d0", 32'(oDataOut[15:0]), 32'(m_d[0]));
        chk("model_d1", 32'(oDataOut[31:16]), 32'(m_d[1]));
        chk("model_err", 32'(oAddrError), 32'(m_err));
        chk("model_rdy", 32'(oReady), 32'(m_ready));
    endtask

    typedef struct {
        bit          clr;
        bit          we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [15:0] e0;
        logic [15:0] e1;
        bit          eerr;
        bit          erdy;
    } vec_t;

    vec_t tbl [9];
    int   cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 1, 8'd3,  16'h1234, 8'd0, 8'd1,  CV, CV, 0, 1};
        tbl[1] = '{0, 0, 8'd0,  16'h0000, 8'd3, 8'd4,  16'h1234, CV, 0, 1};
        tbl[2] = '{0, 1, 8'd5,  16'hBEEF, 8'd0, 8'd5,  CV, BYP ? 16'hBEEF : CV, 0, 1};
        tbl[3] = '{0, 0, 8'd0,  16'h0000, 8'd5, 8'd5,  16'hBEEF, 16'hBEEF, 0, 1};
        tbl[4] = '{0, 1, 8'd20, 16'hDEAD, 8'd4, 8'd20, CV, 16'h0000, 1, 1};
        tbl[5] = '{0, 0, 8'd0,  16'h0000, 8'd4, 8'd3,  CV, 16'h1234, 0, 1};
        tbl[6] = '{0, 1, 8'd4,  16'h4444, 8'd4, 8'd20, BYP ? 16'h4444 : CV, 16'h0000, 1, 1};
        tbl[7] = '{0, 0, 8'd0,  16'h0000, 8'd4, 8'd4,  16'h4444, 16'h4444, 0, 1};
        tbl[8] = '{1, 1, 8'd2,  16'h0F0F, 8'd2, 8'd3,  CV, 16'h1234, 0, 0};

        model_reset();
        #12;
        chk("rst_dout", 32'(oDataOut), 32'd0);
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_err", 32'(oAddrError), 32'd0);

        @(negedge Clock);
        Reset = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40 && cyc == 0; c++) begin
            step(0, 0, 8'd0, 16'd0, 8'd0, 8'd0);
            if (oReady) cyc = c;
        end
        chk("ready_latency", 32'(cyc), 32'd16);

        for (int i = 0; i < MS; i++) begin
            step(0, 0, 8'd0, 16'd0, 8'(i), 8'(MS-1-i));
            chk("clear_rd0", 32'(oDataOut[15:0]), 32'(CV));
            chk("clear_rd1", 32'(oDataOut[31:16]), 32'(CV));
        end

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].clr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1);
            chk($sformatf("vec%0d_d0", i), 32'(oDataOut[15:0]), 32'(tbl[i].e0));
            chk($sformatf("vec%0d_d1", i), 32'(oDataOut[31:16]), 32'(tbl[i].e1));
            chk($sformatf("vec%0d_err", i), 32'(oAddrError), 32'(tbl[i].eerr));
            chk($sformatf("vec%0d_rdy", i), 32'(oReady), 32'(tbl[i].erdy));
        end

        // Sweep triggered by vec8: writes and a repeated iClear inside it are ignored.
        for (int c = 1; c <= MS; c++) begin
            step(c == 5, 1, 8'd7, 16'hFFFF, 8'd7, 8'd2);
            chk("sweep_rdy", 32'(oReady), 32'(c == MS));
            chk("sweep_d0", 32'(oDataOut[15:0]), 32'd0);
        end
        step(0, 0, 8'd0, 16'd0, 8'd2, 8'd7);
        chk("after_clr_a2", 32'(oDataOut[15:0]), 32'(CV));
        chk("after_clr_a7", 32'(oDataOut[31:16]), 32'(CV));
        step(0, 0, 8'd0, 16'd0, 8'd3, 8'd4);
        chk("after_clr_a3", 32'(oDataOut[15:0]), 32'(CV));
        chk("after_clr_a4", 32'(oDataOut[31:16]), 32'(CV));

        // Reset in the middle of a sweep restarts it from address 0.
        step(0, 1, 8'd9, 16'h9999, 8'd0, 8'd0);
        step(1, 0, 8'd0, 16'd0, 8'd9, 8'd0);
        for (int c = 0; c < 7; c++) step(0, 0, 8'd0, 16'd0, 8'd0, 8'd0);
        #2;
        Reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(oReady), 32'd0);
        chk("midrst_dout", 32'(oDataOut), 32'd0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40 && cyc == 0; c++) begin
            step(0, 1, 8'd9, 16'h7777, 8'd9, 8'd1);
            if (oReady) cyc = c;
        end
        chk("midrst_latency", 32'(cyc), 32'd16);
        step(0, 0, 8'd0, 16'd0, 8'd9, 8'd9);
        chk("midrst_a9_p0", 32'(oDataOut[15:0]), 32'(CV));
        chk("midrst_a9_p1", 32'(oDataOut[31:16]), 32'(CV));

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 23)), 16'($urandom),
                 8'($urandom_range(0, 23)), 8'($urandom_range(0, 23)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
